pc_fetch_ctrl: RTL and testbench

//  Owns the program counter and front-end fetch. Issues one instruction-memory request at a time.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pc_fetch_ctrl_if.sv | 23 ++
 rtl/pc_fetch_ctrl_fetch_buf.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared front-end types and widths for the fetch controller slice.
package pipe_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_t;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory request/ack plus the valid/ready link to decode.
interface pc_fetch_ctrl_if;
  import pipe_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// One-entry valid/ready holding register between fetch and decode; flush beats refill and accept.
module fetch_buf
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= ZERO_WORD;
      inst  <= ZERO_WORD;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (ready) valid <= 1'b0;
      if (load) begin
        pc   <= load_pc;
        inst <= load_inst;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and single-outstanding instruction fetch FSM with branch redirect and drop handling.
// Optional perf counters (perf_redirect_cnt, perf_stall_cnt) when FETCH_PERF_CNT_EN is defined.
module pc_fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  pc_fetch_ctrl_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_redirect_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic              load;

  // A redirect arriving with the ack discards the returned word.
  assign load = (state == S_WAIT) && bus.imem_ack && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (branch_taken) begin
            pc <= branch_addr;
          end else if (!buf_valid || bus.if_ready) begin
            req_q  <= 1'b1;
            addr_q <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            req_q <= 1'b0;
            state <= S_IDLE;
            pc    <= branch_taken ? branch_addr : pc + PC_INC;
          end else if (branch_taken) begin
            pc    <= branch_addr;
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (branch_taken) pc <= branch_addr;
          if (bus.imem_ack) begin
            req_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .load      (load),
    .load_pc   (pc),
    .load_inst (bus.imem_rdata),
    .ready     (bus.if_ready),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = buf_valid;
  assign bus.if_pc     = buf_pc;
  assign bus.if_inst   = buf_inst;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirect_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (branch_taken)                 perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (buf_valid && !bus.if_ready)   perf_stall_cnt    <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: transaction-level fetch model plus directed and random phases.
module tb_pc_fetch_ctrl;
  import pipe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  pc_fetch_ctrl_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .PC_INC(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  int unsigned rdy_pct = 100, br_pct = 0, spur_pct = 0, rst_pm = 0, lat_min = 0, lat_max = 0;
  bit          hold_ack = 0, rst_knob = 1, f_br = 0, f_ack = 0, f_rst = 0;
  logic [31:0] f_addr = '0;

  // Reference model state
  logic [63:0] q[$];
  logic [31:0] iss_addr[$];
  int unsigned iss_cyc[$];
  bit          armed = 0, rst_prev = 0, outstanding = 0, poison = 0;
  logic [31:0] m_pc = RST_PC, req_addr = '0, m_redir = '0, m_stall = '0;
  int unsigned cyc = 0;

  // Driver: memory responder, decode ready, random redirects and resets
  initial begin
    int unsigned wait_cnt = 0;
    int unsigned lat = 0;
    rst = 1'b1; branch_taken = 1'b0; branch_addr = '0;
    bus.if_ready = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      rst = rst_knob || f_rst || ($urandom_range(0, 999) < rst_pm);
      f_rst = 0;
      if (f_br) begin
        branch_taken = 1'b1; branch_addr = f_addr; f_br = 0;
      end else if ($urandom_range(0, 99) < br_pct) begin
        branch_taken = 1'b1;
        branch_addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      end else begin
        branch_taken = 1'b0;
      end
      bus.if_ready   = ($urandom_range(0, 99) < rdy_pct);
      bus.imem_rdata = $urandom;
      if (f_ack) begin
        bus.imem_ack = 1'b1; f_ack = 0;
      end else if (hold_ack) bus.imem_ack = 1'b0;
      else if (bus.imem_req) bus.imem_ack = (wait_cnt >= lat);
      else bus.imem_ack = ($urandom_range(0, 99) < spur_pct);
      if (bus.imem_req && !bus.imem_ack) wait_cnt++;
      else begin
        wait_cnt = 0;
        lat = $urandom_range(lat_min, lat_max);
      end
    end
  end

  // Monitor: compares the decode-facing buffer with the expected queue and retires handshakes
  always @(negedge clk) begin
    if (armed) begin
      chk("if_valid", {31'b0, bus.if_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("if_pc", bus.if_pc, q[0][63:32]);
        chk("if_inst", bus.if_inst, q[0][31:0]);
        if (bus.if_ready && !branch_taken && !rst) q.delete(0);
      end
    end
  end

  // Model: tracks PC, the outstanding fetch and redirects; pushes expected buffer entries
  always @(negedge clk) begin
    #2;
    if (armed) begin
      if (rst_prev) begin
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirect", perf_redirect_cnt, m_redir);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    end
    if (rst) begin
      armed = 1; rst_prev = 1; m_pc = RST_PC; q.delete();
      outstanding = 0; poison = 0; m_redir = '0; m_stall = '0;
    end else if (armed) begin
      rst_prev = 0;
      cyc++;
      if (branch_taken) m_redir = m_redir + 32'd1;
      if (q.size() != 0 && !bus.if_ready) m_stall = m_stall + 32'd1;
      if (bus.imem_req === 1'b1) begin
        if (!outstanding) begin
          chk("issue_while_full", 32'(q.size()), 32'd0);
          chk("issue_addr", bus.imem_addr, m_pc);
          outstanding = 1; req_addr = m_pc;
          iss_addr.push_back(bus.imem_addr);
          iss_cyc.push_back(cyc);
        end else begin
          chk("addr_stable", bus.imem_addr, req_addr);
        end
      end else if (outstanding) begin
        chk("req_held", {31'b0, bus.imem_req}, 32'd1);
        outstanding = 0; poison = 0;
      end
      if (outstanding && bus.imem_ack) begin
        if (!poison && !branch_taken) begin
          q.push_back({req_addr, bus.imem_rdata});
          m_pc = req_addr + 32'd4;
        end
        outstanding = 0; poison = 0;
      end
      if (branch_taken) begin
        m_pc = branch_addr;
        q.delete();
        if (outstanding) poison = 1;
      end
    end
  end

  task automatic wait_req(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (bus.imem_req) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_req: no imem_req within %0d cycles", max_cyc);
  endtask

  task automatic wait_valid(input int unsigned max_cyc);
    for (int unsigned i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (bus.if_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_valid: no if_valid within %0d cycles", max_cyc);
  endtask

  task automatic clear_log();
    iss_addr.delete();
    iss_cyc.delete();
  endtask

  initial begin
    logic [31:0] pc0, inst0, a_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall0;
`endif
    // Back-to-back sequential fetch after a 3-cycle reset
    repeat (3) @(posedge clk);
    #2 rst_knob = 0;
    clear_log();
    repeat (14) @(posedge clk);
    #2;
    chk("p1_issue_count", {31'b0, iss_addr.size() >= 3}, 32'd1);
    if (iss_addr.size() >= 3) begin
      chk("p1_addr0", iss_addr[0], 32'h0);
      chk("p1_addr1", iss_addr[1], 32'h4);
      chk("p1_addr2", iss_addr[2], 32'h8);
      chk("p1_gap01", iss_cyc[1] - iss_cyc[0], 32'd2);
      chk("p1_gap12", iss_cyc[2] - iss_cyc[1], 32'd2);
    end

    // Decode stall with a full buffer
    rdy_pct = 0;
    wait_valid(20);
    pc0 = bus.if_pc; inst0 = bus.if_inst;
`ifdef FETCH_PERF_CNT_EN
    stall0 = perf_stall_cnt;
`endif
    repeat (5) @(posedge clk);
    #2;
    chk("p2_valid_held", {31'b0, bus.if_valid}, 32'd1);
    chk("p2_pc_held", bus.if_pc, pc0);
    chk("p2_inst_held", bus.if_inst, inst0);
    chk("p2_no_req", {31'b0, bus.imem_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("p2_stall_delta", perf_stall_cnt - stall0, 32'd5);
`endif
    rdy_pct = 100;

    // Redirect while waiting; ack three cycles later
    hold_ack = 1;
    wait_req(20);
    a_addr = bus.imem_addr;
    f_addr = 32'h100; f_br = 1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    chk("p3_req_held", {31'b0, bus.imem_req}, 32'd1);
    chk("p3_addr_held", bus.imem_addr, a_addr);
    chk("p3_drop_empty", {31'b0, bus.if_valid}, 32'd0);
    f_ack = 1; hold_ack = 0;
    @(posedge clk); #8;
    clear_log();
    repeat (6) @(posedge clk);
    #2;
    chk("p3_issue_count", {31'b0, iss_addr.size() >= 1}, 32'd1);
    if (iss_addr.size() >= 1) chk("p3_target", iss_addr[0], 32'h100);

    // Redirect coincident with ack, from a fresh reset
    rst_knob = 1;
    repeat (2) @(posedge clk);
    #2 rst_knob = 0;
    hold_ack = 1;
    wait_req(20);
    f_addr = 32'h40; f_br = 1; f_ack = 1;
    @(posedge clk); #8;
    clear_log();
    hold_ack = 0;
    repeat (6) @(posedge clk);
    #2;
    chk("p4_issue_count", {31'b0, iss_addr.size() >= 1}, 32'd1);
    if (iss_addr.size() >= 1) chk("p4_target", iss_addr[0], 32'h40);
`ifdef FETCH_PERF_CNT_EN
    chk("p4_redirect_cnt", perf_redirect_cnt, 32'd1);
`endif

    // PC wrap at the top of the address space
    f_addr = 32'hFFFF_FFFC; f_br = 1;
    @(posedge clk); #8;
    clear_log();
    repeat (8) @(posedge clk);
    #2;
    chk("p5_issue_count", {31'b0, iss_addr.size() >= 2}, 32'd1);
    if (iss_addr.size() >= 2) begin
      chk("p5_top", iss_addr[0], 32'hFFFF_FFFC);
      chk("p5_wrap", iss_addr[1], 32'h0);
    end

    // Reset mid-request with an ack in the reset cycle
    hold_ack = 1;
    wait_req(20);
    f_rst = 1; f_ack = 1;
    @(posedge clk); #8;
    clear_log();
    hold_ack = 0;
    @(posedge clk); #2;
    chk("p6_req", {31'b0, bus.imem_req}, 32'd0);
    chk("p6_addr", bus.imem_addr, RST_PC);
    chk("p6_valid", {31'b0, bus.if_valid}, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    chk("p6_issue_count", {31'b0, iss_addr.size() >= 1}, 32'd1);
    if (iss_addr.size() >= 1) chk("p6_first_addr", iss_addr[0], RST_PC);

    // Random traffic
    rdy_pct = 70; br_pct = 8; spur_pct = 10; rst_pm = 5; lat_min = 0; lat_max = 4;
    repeat (3000) @(posedge clk);
    rst_pm = 0; br_pct = 0;
    repeat (20) @(posedge clk);
    #8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
